seg7_scan_display: RTL and testbench
====================================

Name: seg7_scan_display

Overview:
Parametrised multiplexed seven-segment driver for the Basys3 display path: a successor to the fixed 4-digit, derived-clock scanner. It runs on the system clock with an internal clock-enable prescaler, and supports NDIG digits, per-digit decimal points, leading-zero blanking and per-digit blink. New display values arrive through a valid/ready load port. Accepted data is committed only at a frame boundary, so a scan never shows a torn value.

Parameters:
NDIG, 4, number of digits (1..8); digit i shows nibble i; digit 0 is rightmost.
PRESCALE, 100000, clk cycles per digit slot (>=2).
BLINK_FRAMES, 256, full scan frames per blink half-period (>=1).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
load_valid  in  1  load request
load_ready  out  1  pending slot free
load_data  in  4*NDIG  hex nibbles, nibble i at [4i+3:4i]
load_dp  in  NDIG  decimal-point enables, bit i for digit i
blank_lz  in  1  leading-zero blanking enable (live)
blink_en  in  NDIG  per-digit blink enable (live)
seg  out  7  active-low segments {g,f,e,d,c,b,a}
dp  out  1  active-low decimal point
an  out  NDIG  active-low anode enables
frame_start  out  1  one-cycle pulse when digit 0 becomes active

Behaviour:
- Reset (reset=0, async):
  - internal state: pcnt=0, sel=0, shadow data/dp=0, pending empty, frame counter=0, blink_phase=0.
  - outputs: an=all 1, seg=7'b1111111, dp=1, load_ready=1, frame_start=0.
  - Any pending load is dropped.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps.
  - tick = (pcnt==PRESCALE-1).
  - On tick, sel advances and wraps NDIG-1 -> 0.
  - boundary = tick && sel==NDIG-1.
- Load handshake:
  - Accept when load_valid && load_ready; load_data/load_dp are captured into pending, and load_ready=0 from the next cycle.
  - On a boundary cycle with pending held from an earlier cycle: pending -> shadow, pending cleared, load_ready=1 the next cycle.
  - An acceptance in the boundary cycle itself is not bypassed. It waits for the following boundary.
  - load_valid while load_ready=0 is ignored; the requester holds its data.
- Outputs:
  - All outputs are registered, updated every cycle from the current sel/shadow/phase, so there is 1-cycle latency after reset release or a sel change.
  - an = ~(1<<sel).
  - seg = decode(shadow nibble sel).
  - dp = ~shadow_dp[sel].
- Leading-zero blanking: if blank_lz=1 and sel!=0 and nibbles sel..NDIG-1 are all zero, then seg=1111111 and dp=1. Digit 0 is never blanked.
- Blink:
  - The frame counter increments on boundary.
  - When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - While blink_phase=1, digits with blink_en[sel]=1 output seg=1111111 and dp=1; their anode still scans.
- frame_start: registered, high for one cycle together with the output update that shows sel=0.
- Width rules:
  - pcnt width $clog2(PRESCALE).
  - sel width max(1,$clog2(NDIG)).
  - Frame counter width max(1,$clog2(BLINK_FRAMES)).
  - No overflow beyond the explicit wraps.

Decomposition:
- Shared package seg7_pkg holds:
  - SEG_BLANK=7'b1111111 and SEG_DASH=7'b0111111.
  - A 16-entry hex table, active-low {g..a}, e.g.:
    - 0=1000000, 1=1111001, 5=0010010, 8=0000000, A=0001000, F=0001110.
- One sub-module, seg7_hex_decode (combinational nibble -> segments, uses the package table).
- Scan/handshake logic stays in seg7_scan_display.

Test Plan:
All scenarios use NDIG=4, PRESCALE=4, BLINK_FRAMES=2.
1. Release reset, no load -> an cycles 1110,1101,1011,0111, 4 cycles each; seg=1000000 throughout; frame_start pulses every 16 cycles.
2. Load 0x12AF mid-frame -> load_ready low next cycle; display still shows 0000 until the boundary; next frame shows digit0 0001110, digit1 0001000, digit2 0100100, digit3 1111001; load_ready=1 the cycle after the boundary.
3. Load issued in the exact boundary cycle -> not shown in the next frame; shown in the frame after.
4. blank_lz=1, data 0x0005, dp=0001 -> digits 3..1 show seg=1111111, dp=1; digit0 shows seg=0010010, dp=0.
5. blink_en=0100, data 0x8888 -> digit2 shows 0000000 for 2 frames, then 1111111 for 2 frames, repeating; other digits are steady.
6. Pending load held, reset pulsed low mid-slot -> outputs immediately an=1111, seg=1111111; after release load_ready=1, shadow=0, and the dropped value is never displayed.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: blank/dash patterns and
// the active-low {g,f,e,d,c,b,a} hex glyph table.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] HEX_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Holding register for a load waiting for the next frame boundary.
  typedef enum logic {
    SLOT_FREE = 1'b0,
    SLOT_HELD = 1'b1
  } slot_state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_TABLE[nibble];

endmodule

// File: rtl/seg7_scan_display.sv
// Multiplexed NDIG-digit seven-segment scanner with prescaled slot timing,
// frame-synchronous value commit, leading-zero blanking and per-digit blink.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int NDIG         = 4,
  parameter int PRESCALE     = 100000,
  parameter int BLINK_FRAMES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_valid,
  output logic                 load_ready,
  input  logic [4*NDIG-1:0]    load_data,
  input  logic [NDIG-1:0]      load_dp,
  input  logic                 blank_lz,
  input  logic [NDIG-1:0]      blink_en,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [NDIG-1:0]      an,
  output logic                 frame_start
);

  localparam int PCW = $clog2(PRESCALE);
  localparam int SW  = clog2_min1(NDIG);
  localparam int FW  = clog2_min1(BLINK_FRAMES);

  logic [PCW-1:0]    pcnt_q, pcnt_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [FW-1:0]     fcnt_q, fcnt_d;
  logic              blink_phase_q, blink_phase_d;
  slot_state_e       slot_q, slot_d;
  logic [4*NDIG-1:0] pend_data_q, pend_data_d;
  logic [NDIG-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NDIG-1:0] shadow_data_q, shadow_data_d;
  logic [NDIG-1:0]   shadow_dp_q, shadow_dp_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [NDIG-1:0]   an_q, an_d;
  logic              frame_start_q, frame_start_d;

  logic              tick;
  logic              boundary;
  logic [3:0]        cur_nib;
  logic              cur_dp_bit;
  logic              cur_blink;
  logic              upper_zero;
  logic [6:0]        dec_seg;

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q        <= '0;
      sel_q         <= '0;
      fcnt_q        <= '0;
      blink_phase_q <= 1'b0;
      slot_q        <= SLOT_FREE;
      pend_data_q   <= '0;
      pend_dp_q     <= '0;
      shadow_data_q <= '0;
      shadow_dp_q   <= '0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b1;
      an_q          <= '1;
      frame_start_q <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      sel_q         <= sel_d;
      fcnt_q        <= fcnt_d;
      blink_phase_q <= blink_phase_d;
      slot_q        <= slot_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    tick          = (pcnt_q == PCW'(PRESCALE - 1));
    boundary      = tick && (sel_q == SW'(NDIG - 1));
    pcnt_d        = tick ? '0 : pcnt_q + 1'b1;
    sel_d         = sel_q;
    fcnt_d        = fcnt_q;
    blink_phase_d = blink_phase_q;

    if (tick) begin
      sel_d = boundary ? '0 : sel_q + 1'b1;
    end

    if (boundary) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d        = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  // A load taken on a boundary cycle lands in the slot and waits a full frame,
  // so the shadow only ever changes between complete scans.
  always_comb begin
    slot_d        = slot_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;

    case (slot_q)
      SLOT_FREE: begin
        if (load_valid) begin
          slot_d      = SLOT_HELD;
          pend_data_d = load_data;
          pend_dp_d   = load_dp;
        end
      end
      SLOT_HELD: begin
        if (boundary) begin
          slot_d        = SLOT_FREE;
          shadow_data_d = pend_data_q;
          shadow_dp_d   = pend_dp_q;
        end
      end
      default: slot_d = SLOT_FREE;
    endcase
  end

  always_comb begin
    cur_nib    = 4'h0;
    cur_dp_bit = 1'b0;
    cur_blink  = 1'b0;
    upper_zero = 1'b1;
    an_d       = '1;
    for (int i = 0; i < NDIG; i++) begin
      if (sel_q == SW'(i)) begin
        cur_nib    = shadow_data_q[4*i +: 4];
        cur_dp_bit = shadow_dp_q[i];
        cur_blink  = blink_en[i];
        an_d[i]    = 1'b0;
      end
      if ((i >= int'(sel_q)) && (shadow_data_q[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
  end

  // Digit 0 is never zero-blanked so a value of all zeros still shows "0".
  always_comb begin
    logic hide;
    hide          = (blank_lz && (sel_q != '0) && upper_zero) ||
                    (blink_phase_q && cur_blink);
    seg_d         = hide ? SEG_BLANK : dec_seg;
    dp_d          = hide ? 1'b1 : ~cur_dp_bit;
    frame_start_d = (sel_q == '0) && (pcnt_q == '0);
  end

  assign load_ready  = (slot_q == SLOT_FREE);
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a cycle-indexed arithmetic model
// predicts every output; a negedge monitor pops and compares.
module tb_seg7_scan_display;

  localparam int N  = 4;
  localparam int P  = 4;
  localparam int BF = 2;
  localparam int PN = P * N;

  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       rdy;
    int         t;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [15:0]   load_data = '0;
  logic [3:0]    load_dp = '0;
  logic          blank_lz = 1'b0;
  logic [3:0]    blink_en = '0;
  logic [6:0]    seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_start;

  exp_t          exp_q [$];
  int            n_checks = 0;
  int            n_pass = 0;

  int            t;
  logic [15:0]   cur_data;
  logic [3:0]    cur_dp;
  logic          pend_v;
  logic [15:0]   pend_data;
  logic [3:0]    pend_dp;
  int            pend_tb;
  logic [15:0]   s_data;
  logic [3:0]    s_dp;
  logic          s_blz;
  logic [3:0]    s_blk;
  logic          accepted;
  logic          blz_g = 1'b0;
  logic [3:0]    blk_g = '0;

  seg7_scan_display #(
    .NDIG         (N),
    .PRESCALE     (P),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_dp     (load_dp),
    .blank_lz    (blank_lz),
    .blink_en    (blink_en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic exp_t reset_exp(input int tt);
    exp_t e;
    e.an  = 4'hF;
    e.seg = 7'h7F;
    e.dp  = 1'b1;
    e.fs  = 1'b0;
    e.rdy = 1'b1;
    e.t   = tt;
    return e;
  endfunction

  // Outputs seen during cycle u+1 reflect the display state of cycle u.
  function automatic exp_t model_out(input int u);
    exp_t        e;
    int          sel;
    int          frame;
    logic        phase;
    logic [15:0] upper;
    logic        hide;
    sel   = (u / P) % N;
    frame = u / PN;
    phase = ((frame / BF) % 2) == 1;
    upper = s_data >> (4 * sel);
    hide  = (s_blz && sel != 0 && upper == 16'h0) || (phase && s_blk[sel]);
    e.an  = ~(4'b0001 << sel);
    e.seg = hide ? 7'h7F : HEX[upper[3:0]];
    e.dp  = hide ? 1'b1 : ~s_dp[sel];
    e.fs  = (u % PN) == 0;
    e.rdy = 1'b1;
    e.t   = u + 1;
    return e;
  endfunction

  task automatic cmp(input string name, input logic [6:0] got, input logic [6:0] want, input int tt);
    n_checks++;
    if (got === want) n_pass++;
    else $display("[TB] FAIL %s at t=%0d: got %b want %b", name, tt, got, want);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp("an",          {3'b0, an},          {3'b0, e.an},  e.t);
    cmp("seg",         seg,                 e.seg,         e.t);
    cmp("dp",          {6'b0, dp},          {6'b0, e.dp},  e.t);
    cmp("frame_start", {6'b0, frame_start}, {6'b0, e.fs},  e.t);
    cmp("load_ready",  {6'b0, load_ready},  {6'b0, e.rdy}, e.t);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
  end

  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic [3:0] dpv,
                               input logic blz, input logic [3:0] blk);
    exp_t e;
    e = (t == 0) ? reset_exp(t) : model_out(t - 1);
    if (pend_v && pend_tb < t) begin
      cur_data = pend_data;
      cur_dp   = pend_dp;
      pend_v   = 1'b0;
    end
    e.rdy = !pend_v;
    exp_q.push_back(e);
    load_valid = v;
    load_data  = d;
    load_dp    = dpv;
    blank_lz   = blz;
    blink_en   = blk;
    accepted   = v && !pend_v;
    if (accepted) begin
      pend_v    = 1'b1;
      pend_data = d;
      pend_dp   = dpv;
      pend_tb   = (t / PN) * PN + PN - 1;
      if (pend_tb == t) pend_tb += PN;
    end
    s_data = cur_data;
    s_dp   = cur_dp;
    s_blz  = blz;
    s_blk  = blk;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'h0, 4'h0, blz_g, blk_g);
  endtask

  task automatic waitSlot(input int pos);
    int guard = 0;
    while ((t % PN) != pos && guard < 100) begin
      idle(1);
      guard++;
    end
  endtask

  task automatic loadWord(input logic [15:0] d, input logic [3:0] dpv);
    int guard = 0;
    do begin
      applyStimulus(1'b1, d, dpv, blz_g, blk_g);
      guard++;
    end while (!accepted && guard < 100);
    load_valid = 1'b0;
    if (!accepted) begin
      n_checks++;
      $display("[TB] FAIL load_accept: got none want accept within 100 cycles");
    end
  endtask

  // Reset is asserted mid-cycle, so outputs must clear before the next edge.
  task automatic resetDut(input int n);
    load_valid = 1'b0;
    reset = 1'b0;
    exp_q.push_back(reset_exp(-1));
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(reset_exp(-1));
    end
    @(posedge clk);
    #1;
    reset    = 1'b1;
    t        = 0;
    cur_data = '0;
    cur_dp   = '0;
    pend_v   = 1'b0;
  endtask

  initial begin
    logic        req;
    logic [15:0] rd;
    logic [3:0]  rdp;
    t = 0; cur_data = '0; cur_dp = '0; pend_v = 1'b0;
    s_data = '0; s_dp = '0; s_blz = 1'b0; s_blk = '0;
    @(posedge clk);
    #1;
    resetDut(3);

    idle(40);

    waitSlot(5);
    loadWord(16'h12AF, 4'h0);
    idle(40);

    waitSlot(PN - 1);
    applyStimulus(1'b1, 16'h3C7D, 4'b1010, blz_g, blk_g);
    load_valid = 1'b0;
    idle(40);

    blz_g = 1'b1;
    loadWord(16'h0005, 4'b0001);
    idle(40);

    blz_g = 1'b0;
    blk_g = 4'b0100;
    loadWord(16'h8888, 4'h0);
    idle(8 * PN);
    blk_g = 4'b0000;

    waitSlot(3);
    loadWord(16'hBEEF, 4'hF);
    idle(1);
    resetDut(2);
    idle(60);

    req = 1'b0; rd = '0; rdp = '0;
    for (int i = 0; i < 600; i++) begin
      if (i % 64 == 0) begin
        blz_g = 1'($urandom_range(0, 1));
        blk_g = 4'($urandom);
      end
      if (!req) begin
        req = ($urandom_range(0, 3) == 0);
        rd  = 16'($urandom);
        if ($urandom_range(0, 2) == 0) rd = rd & 16'h00FF;
        rdp = 4'($urandom);
      end
      applyStimulus(req, rd, rdp, blz_g, blk_g);
      if (accepted) req = 1'b0;
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
